midi_voice_scheduler: RTL and testbench
=======================================

// Module: midi_voice_scheduler
// PURPOSE
//  Shares one midi_note_sender between N_VOICES note requesters (seq_player-style voices).
//  Latches each voice's note request, picks one by round-robin, and drives the sender's
//  trigger/note/velocity. Paces issue on the sender's busy handshake.
//  Sits between the voice generators and the single UART MIDI sender in top.
// PARAMETERS
//  N_VOICES     4       number of requesting voices (2..8)
//  CHANNEL      4'd0    MIDI channel driven on send_channel
//  VELOCITY     7'd100  velocity for note-on; note-off is sent as note-on with velocity 0
//  GATE_CYCLES  2700000 note length in clk cycles before auto note-off (macro only)
//  ACCEPT_TO    4       max cycles to wait for busy to rise after trigger
// PORTS
//  clk           in   1           system clock
//  rst_n         in   1           asynchronous active-low reset
//  req           in   N_VOICES    1-cycle pulse per voice: new note requested
//  req_note      in   7*N_VOICES  note for voice i at [7*i+:7]; sampled when req[i]=1
//  sender_busy   in   1           busy from midi_note_sender
//  send_trigger  out  1           1-cycle pulse to sender
//  send_channel  out  4           = CHANNEL
//  send_note     out  8           {1'b0, note}; held stable from trigger until busy falls
//  send_velocity out  7           VELOCITY for note-on, 0 for note-off
//  grant         out  N_VOICES    1-cycle one-hot pulse, coincident with send_trigger
//  drop          out  N_VOICES    1-cycle pulse: pending note-on for voice overwritten
// BEHAVIOUR
//  Reset: all outputs 0 except send_channel=CHANNEL; all pending/active flags clear;
//   round-robin pointer=0; FSM=IDLE. Reset mid-message drops all queued work.
//   The sender keeps running independently.
//  Per voice: pend_on, pend_note[6:0]. With macro, also active, act_note[6:0], gate_cnt, pend_off.
//  req[i]: pend_on<=1, pend_note<=req_note[i]. If pend_on was already 1 and not granted
//   this cycle, drop[i] pulses. If granted in the same cycle, the new req becomes pending.
//  Eligibility: pend_off beats pend_on globally. Within a class, round-robin from the
//   pointer. After a grant, the pointer moves to the granted index+1 (mod N_VOICES).
//  FSM: IDLE -> (any eligible & !sender_busy) ISSUE.
//   ISSUE: send_trigger=1 and grant pulse, one cycle; clear the served pending flag; go to ACCEPT.
//   ACCEPT: wait for sender_busy=1, then go to DRAIN. After ACCEPT_TO cycles without busy,
//    go to IDLE (sender dropped it; do not retry).
//   DRAIN: wait for sender_busy=0, then go to IDLE.
//  Latency: req with an idle sender and no competition -> send_trigger 2 cycles later
//   (latch cycle, then ISSUE). Back-to-back: one IDLE cycle between busy fall and next trigger.
//  send_note/send_velocity are registered at ISSUE and held until the next ISSUE.
// CONFIGURATION
//  MIDI_AUTO_NOTE_OFF_EN defined:
//   - Granting a note-on sets active=1, act_note=note, gate_cnt=GATE_CYCLES-1.
//   - gate_cnt counts down each cycle; at 0 it sets pend_off.
//   - A granted note-off (velocity 0, act_note) clears active.
//   - Retrigger: req on an active voice forces pend_off immediately. That voice's pend_on
//     is not eligible until active clears, so the off is always sent before the new on.
//  MIDI_AUTO_NOTE_OFF_EN undefined: no gate/off logic; only note-ons are sent
//   (send_velocity always VELOCITY).
// STRUCTURE
//  Package midi_sched_pkg: FSM state enum (IDLE, ISSUE, ACCEPT, DRAIN), MIDI_NOTE_W=7,
//   MIDI_VEL_W=7, MIDI_CH_W=4, VEL_NOTE_OFF=7'd0.
//  Sub-module rr_arbiter #(N): inputs req vector and pointer; outputs one-hot grant and
//   valid. Instantiated twice (off class, on class) with the same pointer.
// TESTING
//  1. Reset, then req[0] with note 60, busy idle -> trigger 2 cycles later; send_note=8'd60,
//     vel=100, grant=0001.
//  2. req[0..3] in the same cycle (notes 60,62,64,65), sender model busy 10 cycles per msg
//     -> grants in order 0,1,2,3; one IDLE cycle after each busy fall.
//  3. Two req[1] (notes 40 then 41) while the sender is busy -> drop[1] pulses once;
//     only 41 is sent.
//  4. Sender model never raises busy -> FSM returns to IDLE after ACCEPT_TO cycles;
//     the next pending voice is served.
//  5. With macro, GATE_CYCLES=20: req[2] note 50 -> note-on; 20 cycles later note-off
//     note 50 vel 0. A retrigger with note 52 mid-gate -> off(50) then on(52).
//  6. Assert rst_n low during DRAIN -> all outputs 0 asynchronously; no trigger until new req.

Source files
------------

// File: rtl/midi_sched_pkg.sv
// midi_sched_pkg: shared constants for the MIDI voice scheduler.
//   FSM state encodings, MIDI field widths and the note-off velocity.
package midi_sched_pkg;

    localparam int MIDI_NOTE_W = 7;
    localparam int MIDI_VEL_W  = 7;
    localparam int MIDI_CH_W   = 4;

    localparam logic [MIDI_VEL_W-1:0] VEL_NOTE_OFF = 7'd0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_ACCEPT = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

endpackage

// File: rtl/midi_voice_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   in  N          requesting lines
//   ptr   in  clog2(N)   highest-priority index
//   gnt   out N          one-hot winner (0 when nothing requests)
//   valid out 1          any request present
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic                 valid
);

    always_comb begin
        int j;
        j     = 0;
        gnt   = '0;
        valid = 1'b0;
        // Scan N positions starting at ptr; first hit wins.
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                gnt[j] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_voice_scheduler.sv
// midi_voice_scheduler: shares one midi_note_sender between N_VOICES requesters.
//   Latches per-voice note requests, picks one round-robin, drives the sender's
//   trigger/note/velocity and paces on sender_busy.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req[N]                1-cycle request pulse per voice
//   req_note[7N]          note for voice i at [7i+:7]
//   sender_busy           busy from the sender
//   send_trigger          1-cycle pulse to the sender
//   send_channel[4]       constant CHANNEL
//   send_note[8]          {0, note}, held until the next issue
//   send_velocity[7]      VELOCITY (note-on) or 0 (note-off)
//   grant[N]              one-hot, coincident with send_trigger
//   drop[N]               pending note-on overwritten by a new request
// Build option: MIDI_AUTO_NOTE_OFF_EN adds per-voice gate timers and note-offs.
module midi_voice_scheduler
    import midi_sched_pkg::*;
#(
    parameter int                    N_VOICES    = 4,
    parameter logic [MIDI_CH_W-1:0]  CHANNEL     = 4'd0,
    parameter logic [MIDI_VEL_W-1:0] VELOCITY    = 7'd100,
`ifdef MIDI_AUTO_NOTE_OFF_EN
    parameter int                    GATE_CYCLES = 2700000,
`endif
    parameter int                    ACCEPT_TO   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_VOICES-1:0]             req,
    input  logic [MIDI_NOTE_W*N_VOICES-1:0] req_note,
    input  logic                            sender_busy,
    output logic                            send_trigger,
    output logic [MIDI_CH_W-1:0]            send_channel,
    output logic [7:0]                      send_note,
    output logic [MIDI_VEL_W-1:0]           send_velocity,
    output logic [N_VOICES-1:0]             grant,
    output logic [N_VOICES-1:0]             drop
);

    localparam int PW = $clog2(N_VOICES);
    localparam int TW = $clog2(ACCEPT_TO + 1);

    logic [1:0]                                state;
    logic [PW-1:0]                             ptr;
    logic [TW-1:0]                             tmo;
    logic [N_VOICES-1:0]                       pend_on;
    logic [N_VOICES-1:0][MIDI_NOTE_W-1:0]      pend_note;
    logic [N_VOICES-1:0]                       elig_on, elig_off;
    logic [N_VOICES-1:0]                       gnt_on, gnt_off, take_on, take_off, take;
    logic                                      vld_on, vld_off, issue_now;
    logic [PW-1:0]                             take_idx;
    logic [MIDI_NOTE_W-1:0]                    sel_note;

`ifdef MIDI_AUTO_NOTE_OFF_EN
    localparam int GW = $clog2(GATE_CYCLES + 1);
    logic [N_VOICES-1:0]                       active, pend_off;
    logic [N_VOICES-1:0][MIDI_NOTE_W-1:0]      act_note;
    logic [N_VOICES-1:0][GW-1:0]               gate_cnt;

    // A sounding voice holds its next note-on back until its note-off is out.
    assign elig_on  = pend_on & ~active;
    assign elig_off = pend_off;
`else
    assign elig_on  = pend_on;
    assign elig_off = '0;
`endif

    rr_arbiter #(.N(N_VOICES)) u_arb_off (.req(elig_off), .ptr(ptr), .gnt(gnt_off), .valid(vld_off));
    rr_arbiter #(.N(N_VOICES)) u_arb_on  (.req(elig_on),  .ptr(ptr), .gnt(gnt_on),  .valid(vld_on));

    // Decision is made in the IDLE cycle; the grant pulse shows in ISSUE.
    assign issue_now = (state == ST_IDLE) && (vld_off || vld_on) && !sender_busy;
    assign take_off  = (issue_now && vld_off) ? gnt_off : '0;
    assign take_on   = (issue_now && !vld_off) ? gnt_on : '0;
    assign take      = take_off | take_on;

    always_comb begin
        take_idx = '0;
        sel_note = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            if (take[i]) take_idx = PW'(i);
            if (take_on[i]) sel_note = pend_note[i];
`ifdef MIDI_AUTO_NOTE_OFF_EN
            if (take_off[i]) sel_note = act_note[i];
`endif
        end
    end

    assign send_trigger = (state == ST_ISSUE);
    assign send_channel = CHANNEL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            tmo           <= '0;
            grant         <= '0;
            send_note     <= '0;
            send_velocity <= '0;
        end else begin
            grant <= '0;
            case (state)
                ST_IDLE: if (issue_now) begin
                    state         <= ST_ISSUE;
                    grant         <= take;
                    send_note     <= {1'b0, sel_note};
                    send_velocity <= vld_off ? VEL_NOTE_OFF : VELOCITY;
                    ptr           <= (take_idx == PW'(N_VOICES - 1)) ? '0 : take_idx + PW'(1);
                end
                ST_ISSUE: begin
                    state <= ST_ACCEPT;
                    tmo   <= '0;
                end
                ST_ACCEPT: begin
                    // No busy within ACCEPT_TO cycles: sender dropped it, move on.
                    if (sender_busy)                      state <= ST_DRAIN;
                    else if (tmo == TW'(ACCEPT_TO - 1))   state <= ST_IDLE;
                    else                                  tmo   <= tmo + TW'(1);
                end
                default: if (!sender_busy) state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_on   <= '0;
            pend_note <= '0;
            drop      <= '0;
`ifdef MIDI_AUTO_NOTE_OFF_EN
            active    <= '0;
            pend_off  <= '0;
            act_note  <= '0;
            gate_cnt  <= '0;
`endif
        end else begin
            for (int i = 0; i < N_VOICES; i++) begin
                drop[i] <= req[i] && pend_on[i] && !take_on[i];
                // A request in the grant cycle stays pending as the next note.
                if (req[i]) begin
                    pend_on[i]   <= 1'b1;
                    pend_note[i] <= req_note[MIDI_NOTE_W*i +: MIDI_NOTE_W];
                end else if (take_on[i]) begin
                    pend_on[i]   <= 1'b0;
                end
`ifdef MIDI_AUTO_NOTE_OFF_EN
                if (take_off[i]) begin
                    active[i]   <= 1'b0;
                    pend_off[i] <= 1'b0;
                end
                if (take_on[i]) begin
                    active[i]   <= 1'b1;
                    act_note[i] <= pend_note[i];
                    gate_cnt[i] <= GW'(GATE_CYCLES - 1);
                end else if (active[i] && !pend_off[i]) begin
                    if (gate_cnt[i] == '0) pend_off[i] <= 1'b1;
                    else                   gate_cnt[i] <= gate_cnt[i] - GW'(1);
                end
                // Retrigger on a voice that is (or is becoming) sounding.
                if (req[i] && (take_on[i] || (active[i] && !take_off[i])))
                    pend_off[i] <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_midi_voice_scheduler.sv
module tb_midi_voice_scheduler;
    localparam int N   = 4;
    localparam int ACC = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [7*N-1:0] req_note = '0;
    logic           sender_busy;
    logic           send_trigger;
    logic [3:0]     send_channel;
    logic [7:0]     send_note;
    logic [6:0]     send_velocity;
    logic [N-1:0]   grant, drop;

    midi_voice_scheduler #(
        .N_VOICES(N), .CHANNEL(4'd0), .VELOCITY(7'd100),
`ifdef MIDI_AUTO_NOTE_OFF_EN
        .GATE_CYCLES(20),
`endif
        .ACCEPT_TO(ACC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_note(req_note),
        .sender_busy(sender_busy), .send_trigger(send_trigger),
        .send_channel(send_channel), .send_note(send_note),
        .send_velocity(send_velocity), .grant(grant), .drop(drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int trig_cnt = 0;
    int drop1_cnt = 0;

    // Sender model: busy for busy_len cycles starting the cycle after a trigger.
    int busy_cnt = 0;
    int busy_len = 10;
    bit never_busy = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (send_trigger && !never_busy) busy_cnt <= busy_len;
        else if (busy_cnt > 0)           busy_cnt <= busy_cnt - 1;
    end
    assign sender_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        if (send_trigger) trig_cnt++;
        if (drop[1]) drop1_cnt++;
    end

    // Reference model: pending set + latest note per voice + rotating priority.
    // It does not decide when a message goes out, only what must go out.
    bit             m_en = 0;
    bit             m_pend[N];
    logic [6:0]     m_note[N];
    int             m_ptr = 0;
    logic [N-1:0]   s_req = '0;
    logic [7*N-1:0] s_note = '0;
    always @(posedge clk) begin
        s_req  <= req;
        s_note <= req_note;
    end
    always @(negedge clk) begin
        logic [N-1:0] exp_g, exp_d;
        int v;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) m_pend[k] = 0;
            m_ptr = 0;
        end else if (m_en) begin
            exp_g = '0;
            exp_d = '0;
            if (send_trigger) begin
                v = -1;
                for (int k = 0; k < N; k++)
                    if (v < 0 && m_pend[(m_ptr + k) % N]) v = (m_ptr + k) % N;
                checks++;
                if (v < 0) begin
                    errors++;
                    $display("FAIL model_spurious_trigger grant=%b note=%0d", grant, send_note);
                end else begin
                    exp_g[v] = 1'b1;
                    if (grant !== exp_g || send_note !== {1'b0, m_note[v]} || send_velocity !== 7'd100) begin
                        errors++;
                        $display("FAIL model_grant got g=%b n=%0d v=%0d want g=%b n=%0d v=100",
                                 grant, send_note, send_velocity, exp_g, m_note[v]);
                    end
                    m_pend[v] = 0;
                    m_ptr = (v + 1) % N;
                end
            end else begin
                checks++;
                if (grant !== '0) begin
                    errors++;
                    $display("FAIL model_grant_idle got %b want 0", grant);
                end
            end
            for (int k = 0; k < N; k++)
                if (s_req[k]) begin
                    if (m_pend[k]) exp_d[k] = 1'b1;
                    m_pend[k] = 1;
                    m_note[k] = s_note[7*k +: 7];
                end
            checks++;
            if (drop !== exp_d) begin
                errors++;
                $display("FAIL model_drop got %b want %b", drop, exp_d);
            end
        end
    end

    function automatic logic [7*N-1:0] mk(input int v, input int n);
        logic [7*N-1:0] r;
        r = '0;
        r[7*v +: 7] = 7'(n);
        return r;
    endfunction

    // All tasks are entered and left on a negedge.
    task automatic pulse_req(input logic [N-1:0] r, input logic [7*N-1:0] notes);
        req = r;
        req_note = notes;
        @(negedge clk);
        req = '0;
    endtask

    task automatic wait_trig(output int n);
        n = 0;
        while (!send_trigger && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!send_trigger) begin
            checks++;
            errors++;
            $display("FAIL trigger_timeout waited %0d cycles", n);
        end
    endtask

    task automatic do_reset();
        int n;
        n = 0;
        never_busy = 0;
        while (sender_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        checks++;
        if (send_trigger !== 1'b0 || grant !== '0 || drop !== '0 || send_note !== 8'd0 ||
            send_velocity !== 7'd0 || send_channel !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs got t=%b g=%b d=%b n=%0d v=%0d ch=%0d want 0",
                     send_trigger, grant, drop, send_note, send_velocity, send_channel);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        do_reset();
        pulse_req(4'b0001, mk(0, 60));
        wait_trig(n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL single_latency got %0d want 1", n); end
        checks++;
        if (grant !== 4'b0001 || send_note !== 8'd60 || send_velocity !== 7'd100) begin
            errors++;
            $display("FAIL single_msg got g=%b n=%0d v=%0d want 0001 60 100", grant, send_note, send_velocity);
        end
        @(negedge clk);
    endtask

    task automatic test_rr_order();
        int n, b;
        int notes[4] = '{60, 62, 64, 65};
        do_reset();
        busy_len = 10;
        pulse_req(4'b1111, mk(0, 60) | mk(1, 62) | mk(2, 64) | mk(3, 65));
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                b = 0;
                while (sender_busy && b < 50) begin @(negedge clk); b++; end
            end
            wait_trig(n);
            checks++;
            if (n !== (k == 0 ? 1 : 2)) begin
                errors++;
                $display("FAIL rr_gap_%0d got %0d want %0d", k, n, (k == 0 ? 1 : 2));
            end
            checks++;
            if (grant !== 4'(1 << k) || send_note !== 8'(notes[k])) begin
                errors++;
                $display("FAIL rr_order_%0d got g=%b n=%0d want g=%b n=%0d", k, grant, send_note, 4'(1 << k), notes[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_drop();
        int n, t0;
        do_reset();
        busy_len = 10;
        pulse_req(4'b0001, mk(0, 70));
        wait_trig(n);
        @(negedge clk);
        drop1_cnt = 0;
        pulse_req(4'b0010, mk(1, 40));
        @(negedge clk);
        pulse_req(4'b0010, mk(1, 41));
        repeat (2) @(negedge clk);
        checks++;
        if (drop1_cnt !== 1) begin errors++; $display("FAIL drop_count got %0d want 1", drop1_cnt); end
        wait_trig(n);
        checks++;
        if (grant !== 4'b0010 || send_note !== 8'd41) begin
            errors++;
            $display("FAIL drop_sent got g=%b n=%0d want 0010 41", grant, send_note);
        end
        @(negedge clk);
        t0 = trig_cnt;
        repeat (30) @(negedge clk);
        checks++;
        if (trig_cnt !== t0) begin errors++; $display("FAIL drop_extra got %0d want 0", trig_cnt - t0); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        never_busy = 1;
        pulse_req(4'b0011, mk(0, 30) | mk(1, 31));
        wait_trig(n);
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("FAIL tmo_first got %b want 0001", grant); end
        @(negedge clk);
        wait_trig(n);
        checks++;
        if (n !== ACC + 1) begin errors++; $display("FAIL tmo_gap got %0d want %0d", n, ACC + 1); end
        checks++;
        if (grant !== 4'b0010 || send_note !== 8'd31) begin
            errors++;
            $display("FAIL tmo_next got g=%b n=%0d want 0010 31", grant, send_note);
        end
        @(negedge clk);
        never_busy = 0;
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [7*N-1:0] nt;
        int left;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            busy_len = $urandom_range(1, 6);
            never_busy = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < N; k++) begin
                r[k] = ($urandom_range(0, 11) == 0);
                nt[7*k +: 7] = 7'($urandom_range(0, 127));
            end
            req = r;
            req_note = nt;
            @(negedge clk);
        end
        req = '0;
        never_busy = 0;
        repeat (150) @(negedge clk);
        left = 0;
        for (int k = 0; k < N; k++) if (m_pend[k]) left++;
        checks++;
        if (left !== 0) begin errors++; $display("FAIL rand_drain got %0d pending want 0", left); end
    endtask

`ifdef MIDI_AUTO_NOTE_OFF_EN
    task automatic test_auto_off();
        int n, t0, gap;
        do_reset();
        busy_len = 10;
        pulse_req(4'b0100, mk(2, 50));
        wait_trig(n);
        t0 = cyc;
        checks++;
        if (grant !== 4'b0100 || send_note !== 8'd50 || send_velocity !== 7'd100) begin
            errors++;
            $display("FAIL gate_on got g=%b n=%0d v=%0d want 0100 50 100", grant, send_note, send_velocity);
        end
        @(negedge clk);
        wait_trig(n);
        gap = cyc - t0;
        checks++;
        if (grant !== 4'b0100 || send_note !== 8'd50 || send_velocity !== 7'd0 || gap < 19 || gap > 23) begin
            errors++;
            $display("FAIL gate_off got g=%b n=%0d v=%0d gap=%0d want 0100 50 0 gap~20",
                     grant, send_note, send_velocity, gap);
        end
        @(negedge clk);
        pulse_req(4'b0100, mk(2, 50));
        wait_trig(n);
        repeat (5) @(negedge clk);
        pulse_req(4'b0100, mk(2, 52));
        wait_trig(n);
        checks++;
        if (send_note !== 8'd50 || send_velocity !== 7'd0) begin
            errors++;
            $display("FAIL retrig_off got n=%0d v=%0d want 50 0", send_note, send_velocity);
        end
        @(negedge clk);
        wait_trig(n);
        checks++;
        if (send_note !== 8'd52 || send_velocity !== 7'd100) begin
            errors++;
            $display("FAIL retrig_on got n=%0d v=%0d want 52 100", send_note, send_velocity);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_drain();
        int n, t0;
        do_reset();
        busy_len = 10;
        pulse_req(4'b0011, mk(0, 20) | mk(1, 21));
        wait_trig(n);
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if (send_trigger !== 1'b0 || grant !== '0 || drop !== '0 || send_note !== 8'd0 || send_velocity !== 7'd0) begin
            errors++;
            $display("FAIL drain_reset got t=%b g=%b d=%b n=%0d v=%0d want 0",
                     send_trigger, grant, drop, send_note, send_velocity);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        t0 = trig_cnt;
        repeat (30) @(negedge clk);
        checks++;
        if (trig_cnt !== t0) begin errors++; $display("FAIL drain_no_trigger got %0d want 0", trig_cnt - t0); end
        pulse_req(4'b0100, mk(2, 77));
        wait_trig(n);
        checks++;
        if (grant !== 4'b0100 || send_note !== 8'd77) begin
            errors++;
            $display("FAIL drain_new_req got g=%b n=%0d want 0100 77", grant, send_note);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
`ifdef MIDI_AUTO_NOTE_OFF_EN
        test_auto_off();
`else
        m_en = 1;
        test_single();
        test_rr_order();
        test_drop();
        test_timeout();
        test_random();
`endif
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
